// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU 2-deep result queues drained round-robin onto
// registered ROB writeback lanes. Define WB_ARB_AGING_EN for starvation aging.
module wb_arbiter #(
    parameter int NUM_FU               = 4,
    parameter int WB_PORTS             = 2,
    parameter int ROB_ADDR_WIDTH       = 4,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int AGE_LIMIT            = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_FU-1:0]                    fu_valid,
    output logic [NUM_FU-1:0]                    fu_ready,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0]     fu_rob_addr,
    input  logic [NUM_FU-1:0]                    fu_bank_addr,
    input  logic [NUM_FU*PHYS_REGS_ADDR_WIDTH-1:0] fu_phys_rd,
    input  logic [NUM_FU-1:0]                    fu_is_branch,
    input  logic [NUM_FU-1:0]                    fu_taken,
    output logic [WB_PORTS-1:0]                  wb_en,
    output logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]   wb_rob_addr,
    output logic [WB_PORTS-1:0]                  wb_bank_addr,
    output logic [WB_PORTS*PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
    output logic [WB_PORTS-1:0]                  wb_is_branch,
    output logic [WB_PORTS-1:0]                  wb_taken
);
    localparam int RAW = ROB_ADDR_WIDTH;
    localparam int PRW = PHYS_REGS_ADDR_WIDTH;
    // Entry layout: {taken, is_branch, phys_rd, bank, rob_addr}
    localparam int EW  = RAW + PRW + 3;
    localparam int BR  = EW - 2;
    localparam int PW  = $clog2(NUM_FU);

    if (NUM_FU < 2 || NUM_FU > 8 || WB_PORTS < 1 || AGE_LIMIT < 1) begin : g_bad_cfg
        $error("wb_arbiter: unsupported parameter set");
    end

    logic [NUM_FU-1:0][1:0]      count_q, count_d;
    logic [NUM_FU-1:0][EW-1:0]   head_q, head_d;
    logic [NUM_FU-1:0][EW-1:0]   tail_q, tail_d;
    logic [NUM_FU-1:0][EW-1:0]   in_entry;
    logic [PW-1:0]               rr_q, rr_d;
    logic [WB_PORTS-1:0]         wb_en_q, wb_en_d;
    logic [WB_PORTS-1:0][EW-1:0] lane_q, lane_d;
    logic [NUM_FU-1:0]           gnt, gnt_eff, aged;
    logic                        br_gnt;
    logic [PW-1:0]               br_idx, last;
    logic [WB_PORTS-1:0][PW-1:0] nb_sel;
    logic [WB_PORTS-1:0]         nb_v;
    int                          n_gnt;

    // Ready depends only on registered occupancy and is held low in reset.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = !count_q[i][1] && !rst;
            in_entry[i] = {fu_taken[i], fu_is_branch[i],
                           fu_phys_rd[i*PRW +: PRW], fu_bank_addr[i],
                           fu_rob_addr[i*RAW +: RAW]};
        end
    end

`ifdef WB_ARB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [NUM_FU-1:0][AW-1:0] age_q, age_d;

    // Saturating wait counters for heads that keep losing arbitration.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            aged[i]  = (age_q[i] == AW'(AGE_LIMIT));
            age_d[i] = age_q[i];
            if (flush || gnt_eff[i]) begin
                age_d[i] = '0;
            end else if (count_q[i] != 2'd0 && !aged[i]) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // Age counter register.
    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end
`else
    assign aged = '0;
`endif

    // Grant scan: aged FUs by index first, then round-robin from rr_q.
    always_comb begin
        logic [PW:0] sum;
        logic [PW-1:0] idx;
        logic cand;
        int n_nb;
        gnt    = '0;
        br_gnt = 1'b0;
        br_idx = '0;
        last   = '0;
        nb_sel = '0;
        nb_v   = '0;
        n_gnt  = 0;
        n_nb   = 0;
        for (int k = 0; k < 2 * NUM_FU; k++) begin
            if (k < NUM_FU) begin
                idx  = PW'(k);
                cand = aged[idx];
            end else begin
                sum = {1'b0, rr_q} + (PW+1)'(k - NUM_FU);
                if (sum >= (PW+1)'(NUM_FU)) sum = sum - (PW+1)'(NUM_FU);
                idx  = sum[PW-1:0];
                cand = 1'b1;
            end
            if (cand && !gnt[idx] && count_q[idx] != 2'd0 && n_gnt < WB_PORTS) begin
                if (!head_q[idx][BR]) begin
                    gnt[idx] = 1'b1;
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (p == n_nb) begin
                            nb_sel[p] = idx;
                            nb_v[p]   = 1'b1;
                        end
                    end
                    n_nb  = n_nb + 1;
                    n_gnt = n_gnt + 1;
                    last  = idx;
                end else if (!br_gnt) begin
                    gnt[idx] = 1'b1;
                    br_gnt   = 1'b1;
                    br_idx   = idx;
                    n_gnt    = n_gnt + 1;
                    last     = idx;
                end
            end
        end
        gnt_eff = flush ? '0 : gnt;
    end

    // Lane packing: branch on lane 0, non-branches after it in scan order.
    always_comb begin
        wb_en_d = '0;
        lane_d  = '0;
        rr_d    = rr_q;
        if (!flush) begin
            if (br_gnt) begin
                wb_en_d[0] = 1'b1;
                lane_d[0]  = head_q[br_idx];
            end else if (nb_v[0]) begin
                wb_en_d[0] = 1'b1;
                lane_d[0]  = head_q[nb_sel[0]];
            end
            for (int l = 1; l < WB_PORTS; l++) begin
                if (br_gnt ? nb_v[l-1] : nb_v[l]) begin
                    wb_en_d[l] = 1'b1;
                    lane_d[l]  = head_q[br_gnt ? nb_sel[l-1] : nb_sel[l]];
                end
            end
            if (n_gnt != 0) begin
                rr_d = (last == PW'(NUM_FU - 1)) ? '0 : last + 1'b1;
            end
        end
    end

    // Queue occupancy and storage; flush outranks enqueue and dequeue.
    always_comb begin
        logic [1:0] fill;
        logic enq;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < NUM_FU; i++) begin
            enq  = fu_valid[i] && fu_ready[i] && !flush;
            fill = count_q[i];
            if (gnt_eff[i]) begin
                head_d[i] = tail_q[i];
                fill      = fill - 2'd1;
            end
            if (enq) begin
                if (fill == 2'd0) head_d[i] = in_entry[i];
                else              tail_d[i] = in_entry[i];
                fill = fill + 2'd1;
            end
            count_d[i] = flush ? 2'd0 : fill;
        end
    end

    // State and registered lane outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            rr_q    <= '0;
            wb_en_q <= '0;
            lane_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rr_q    <= rr_d;
            wb_en_q <= wb_en_d;
            lane_q  <= lane_d;
        end
    end

    for (genvar l = 0; l < WB_PORTS; l++) begin : g_lane
        assign wb_rob_addr[l*RAW +: RAW] = lane_q[l][RAW-1:0];
        assign wb_bank_addr[l]           = lane_q[l][RAW];
        assign wb_phys_rd[l*PRW +: PRW]  = lane_q[l][RAW+1 +: PRW];
        assign wb_is_branch[l]           = lane_q[l][BR];
        assign wb_taken[l]               = lane_q[l][EW-1];
    end

    assign wb_en = wb_en_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build: 4 FUs, 2 lanes).
// Expected values are hand-derived per step.
module tb_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [15:0] fu_rob_addr;
    logic [3:0]  fu_bank_addr;
    logic [23:0] fu_phys_rd;
    logic [3:0]  fu_is_branch;
    logic [3:0]  fu_taken;
    logic [1:0]  wb_en;
    logic [7:0]  wb_rob_addr;
    logic [1:0]  wb_bank_addr;
    logic [11:0] wb_phys_rd;
    logic [1:0]  wb_is_branch;
    logic [1:0]  wb_taken;

    int checks = 0;
    int failures = 0;

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_rob_addr  (fu_rob_addr),
        .fu_bank_addr (fu_bank_addr),
        .fu_phys_rd   (fu_phys_rd),
        .fu_is_branch (fu_is_branch),
        .fu_taken     (fu_taken),
        .wb_en        (wb_en),
        .wb_rob_addr  (wb_rob_addr),
        .wb_bank_addr (wb_bank_addr),
        .wb_phys_rd   (wb_phys_rd),
        .wb_is_branch (wb_is_branch),
        .wb_taken     (wb_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [3:0] rob, input logic bank,
                        input logic [5:0] phys, input logic br, input logic tk);
        fu_rob_addr[i*4 +: 4] = rob;
        fu_bank_addr[i]       = bank;
        fu_phys_rd[i*6 +: 6]  = phys;
        fu_is_branch[i]       = br;
        fu_taken[i]           = tk;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = 4'hF;
        fu_rob_addr = '0;
        fu_bank_addr = '0;
        fu_phys_rd = '0;
        fu_is_branch = '0;
        fu_taken = '0;

        // Reset held three cycles with all FUs requesting.
        #1;
        chk("rst_ready_t0", fu_ready, 4'h0);
        repeat (3) begin
            tick();
            chk("rst_ready", fu_ready, 4'h0);
            chk("rst_wb_en", wb_en, 2'b00);
        end
        rst = 1'b0;
        fu_valid = 4'h0;
        #1;
        chk("ready_after_rst", fu_ready, 4'hF);

        // Single result on FU2: two-edge latency, one pulse.
        load(2, 4'd5, 1'b1, 6'd17, 1'b0, 1'b0);
        fu_valid = 4'b0100;
        tick();
        fu_valid = 4'h0;
        chk("single_no_bypass", wb_en, 2'b00);
        tick();
        chk("single_en", wb_en, 2'b01);
        chk("single_rob", wb_rob_addr, 8'h05);
        chk("single_bank", wb_bank_addr, 2'b01);
        chk("single_phys", wb_phys_rd, 12'h011);
        chk("single_br", wb_is_branch, 2'b00);
        tick();
        chk("single_once", wb_en, 2'b00);

        // FU3 single result; rr wraps to 0 afterwards.
        load(3, 4'd9, 1'b0, 6'd0, 1'b0, 1'b0);
        fu_valid = 4'b1000;
        tick();
        fu_valid = 4'h0;
        tick();
        chk("fu3_en", wb_en, 2'b01);
        chk("fu3_rob", wb_rob_addr, 8'h09);
        tick();

        // All four FUs contend from rr=0.
        for (int i = 0; i < 4; i++) begin
            load(i, 4'(i), 1'(i), 6'(10 + i), 1'b0, 1'b0);
        end
        fu_valid = 4'hF;
        tick();
        fu_valid = 4'h0;
        tick();
        chk("cont1_en", wb_en, 2'b11);
        chk("cont1_rob", wb_rob_addr, 8'h10);
        chk("cont1_phys", wb_phys_rd, 12'h2CA);
        chk("cont1_bank", wb_bank_addr, 2'b10);
        tick();
        chk("cont2_en", wb_en, 2'b11);
        chk("cont2_rob", wb_rob_addr, 8'h32);
        chk("cont2_phys", wb_phys_rd, 12'h34C);
        tick();
        chk("cont_drained", wb_en, 2'b00);

        // Branch limiting: FU1 and FU3 branches, FU0 plain.
        load(0, 4'd4, 1'b0, 6'd0, 1'b0, 1'b0);
        load(1, 4'd6, 1'b0, 6'd0, 1'b1, 1'b1);
        load(3, 4'd7, 1'b0, 6'd0, 1'b1, 1'b0);
        fu_valid = 4'b1011;
        tick();
        fu_valid = 4'h0;
        tick();
        chk("br1_en", wb_en, 2'b11);
        chk("br1_rob", wb_rob_addr, 8'h46);
        chk("br1_isbr", wb_is_branch, 2'b01);
        chk("br1_taken", wb_taken, 2'b01);
        tick();
        chk("br2_en", wb_en, 2'b01);
        chk("br2_rob", wb_rob_addr, 8'h07);
        chk("br2_isbr", wb_is_branch, 2'b01);
        chk("br2_taken", wb_taken, 2'b00);
        tick();
        chk("br_drained", wb_en, 2'b00);

        // Backpressure: FU0 starved behind branch limiting, then flush.
        load(1, 4'd1, 1'b0, 6'd0, 1'b0, 1'b0);
        load(2, 4'd2, 1'b0, 6'd0, 1'b0, 1'b0);
        fu_valid = 4'b0110;
        tick();
        load(0, 4'd8, 1'b0, 6'd0, 1'b1, 1'b0);
        load(1, 4'd9, 1'b0, 6'd0, 1'b0, 1'b0);
        load(2, 4'd10, 1'b0, 6'd0, 1'b0, 1'b0);
        load(3, 4'd11, 1'b0, 6'd0, 1'b1, 1'b1);
        fu_valid = 4'hF;
        tick();
        chk("bp_e1_en", wb_en, 2'b11);
        chk("bp_e1_rob", wb_rob_addr, 8'h21);
        load(0, 4'd12, 1'b0, 6'd0, 1'b1, 1'b0);
        load(3, 4'd13, 1'b0, 6'd0, 1'b1, 1'b0);
        fu_valid = 4'b1001;
        tick();
        chk("bp_e2_en", wb_en, 2'b11);
        chk("bp_e2_rob", wb_rob_addr, 8'h9B);
        chk("bp_e2_isbr", wb_is_branch, 2'b01);
        chk("bp_full_ready", fu_ready, 4'b1110);
        load(0, 4'd14, 1'b0, 6'd0, 1'b1, 1'b0);
        fu_valid = 4'b0001;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fu_valid = 4'h0;
        chk("flush_en", wb_en, 2'b00);
        chk("flush_ready", fu_ready, 4'hF);
        tick();
        chk("flush_empty", wb_en, 2'b00);

        // Reset mid-operation discards queued results and clears rr.
        load(0, 4'd1, 1'b0, 6'd0, 1'b0, 1'b0);
        load(1, 4'd2, 1'b0, 6'd0, 1'b0, 1'b0);
        fu_valid = 4'b0011;
        tick();
        fu_valid = 4'h0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", fu_ready, 4'h0);
        tick();
        chk("midrst_en", wb_en, 2'b00);
        rst = 1'b0;
        tick();
        chk("postrst_en", wb_en, 2'b00);
        chk("postrst_ready", fu_ready, 4'hF);
        load(0, 4'd10, 1'b0, 6'd0, 1'b0, 1'b0);
        load(2, 4'd11, 1'b0, 6'd0, 1'b0, 1'b0);
        fu_valid = 4'b0101;
        tick();
        fu_valid = 4'h0;
        tick();
        chk("rr_reset_en", wb_en, 2'b11);
        chk("rr_reset_rob", wb_rob_addr, 8'hBA);
        tick();
        chk("final_idle", wb_en, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
